// File: rtl/rob_multi_if.sv
// Dispatch, writeback and retire bundle of the multi-issue reorder buffer.
// The ROB sits on the slave side; the core (or bench) drives the master side.
interface rob_multi_if #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int WB_PORTS = 3,
  parameter int PREG_W   = 7
);
  localparam int ROB_W = $clog2(DEPTH);

  logic [ALLOC_W-1:0]          alloc_valid_i;
  logic [ALLOC_W-1:0]          alloc_rd_used_i;
  logic [ALLOC_W*PREG_W-1:0]   alloc_old_prd_i;
  logic                        alloc_ready_o;
  logic [ALLOC_W*ROB_W-1:0]    alloc_tag_o;
  logic [WB_PORTS-1:0]         wb_valid_i;
  logic [WB_PORTS*ROB_W-1:0]   wb_tag_i;
  logic [COMMIT_W-1:0]         commit_valid_o;
  logic [COMMIT_W*ROB_W-1:0]   commit_tag_o;
  logic [COMMIT_W-1:0]         commit_free_o;
  logic [COMMIT_W*PREG_W-1:0]  commit_preg_o;
  logic [ROB_W:0]              count_o;
  logic [DEPTH-1:0]            live_tag_o;

  modport master (
    output alloc_valid_i, alloc_rd_used_i,
    output alloc_old_prd_i,
    output wb_valid_i, wb_tag_i,
    input  alloc_ready_o, alloc_tag_o,
    input  commit_valid_o, commit_tag_o,
    input  commit_free_o, commit_preg_o,
    input  count_o, live_tag_o
  );

  modport slave (
    input  alloc_valid_i, alloc_rd_used_i,
    input  alloc_old_prd_i,
    input  wb_valid_i, wb_tag_i,
    output alloc_ready_o, alloc_tag_o,
    output commit_valid_o, commit_tag_o,
    output commit_free_o, commit_preg_o,
    output count_o, live_tag_o
  );
endinterface

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: in-order alloc, out-of-order done marks,
// in-order multi-retire, single-cycle squash of entries younger than a tag.
module rob_multi #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int WB_PORTS = 3,
  parameter int PREG_W   = 7,
  localparam int ROB_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             recover_i,
  input  logic [ROB_W-1:0] recover_tag_i,
  rob_multi_if.slave       bus
);

  logic [ROB_W-1:0]  head_q, head_d;
  logic [ROB_W-1:0]  tail_q, tail_d;
  logic [ROB_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  used_q, used_d;
  logic [PREG_W-1:0] prd_q [DEPTH];
  logic [PREG_W-1:0] prd_d [DEPTH];

  logic                       ready;
  logic [ROB_W:0]             n_alloc;
  logic [ROB_W:0]             n_commit;
  logic [COMMIT_W-1:0]        cm_valid;
  logic [COMMIT_W*ROB_W-1:0]  cm_tag;
  logic [COMMIT_W-1:0]        cm_free;
  logic [COMMIT_W*PREG_W-1:0] cm_preg;
  logic [ALLOC_W*ROB_W-1:0]   a_tag;

  assign ready = count_q <= (ROB_W+1)'(DEPTH - ALLOC_W);

  assign bus.alloc_ready_o  = ready;
  assign bus.alloc_tag_o    = a_tag;
  assign bus.commit_valid_o = cm_valid;
  assign bus.commit_tag_o   = cm_tag;
  assign bus.commit_free_o  = cm_free;
  assign bus.commit_preg_o  = cm_preg;
  assign bus.count_o        = count_q;
  assign bus.live_tag_o     = valid_q;

  always_comb begin : tag_c
    a_tag = '0;
    for (int i = 0; i < ALLOC_W; i++)
      a_tag[i*ROB_W +: ROB_W] = tail_q + ROB_W'(i);
  end

  // Retire stops at the first entry that is not both valid and done.
  always_comb begin : commit_c
    logic             run;
    logic [ROB_W-1:0] idx;
    run      = !flush_i;
    idx      = '0;
    n_commit = '0;
    cm_valid = '0;
    cm_tag   = '0;
    cm_free  = '0;
    cm_preg  = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head_q + ROB_W'(i);
      run = run && valid_q[idx] && done_q[idx]
            && ((ROB_W+1)'(i) < count_q);
      if (run) begin
        cm_valid[i]                 = 1'b1;
        cm_tag[i*ROB_W +: ROB_W]    = idx;
        cm_free[i]                  = used_q[idx]
                                      && (prd_q[idx] != '0);
        if (cm_free[i])
          cm_preg[i*PREG_W +: PREG_W] = prd_q[idx];
        n_commit = n_commit + (ROB_W+1)'(1);
      end
    end
  end

  always_comb begin : next_c
    logic [ROB_W-1:0] idx;
    logic [ROB_W-1:0] off;
    logic [ROB_W-1:0] rel;
    logic             fire;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    used_d  = used_q;
    prd_d   = prd_q;
    idx     = '0;
    off     = '0;
    rel     = recover_tag_i - head_q;
    fire    = ready && !flush_i && !recover_i;
    n_alloc = '0;
    for (int i = 0; i < ALLOC_W; i++)
      n_alloc = n_alloc
                + (ROB_W+1)'(bus.alloc_valid_i[i]);
    if (!fire)
      n_alloc = '0;

    for (int p = 0; p < WB_PORTS; p++) begin
      idx = bus.wb_tag_i[p*ROB_W +: ROB_W];
      if (bus.wb_valid_i[p] && valid_q[idx])
        done_d[idx] = 1'b1;
    end

    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head_q + ROB_W'(i);
      if (cm_valid[i]) begin
        valid_d[idx] = 1'b0;
        done_d[idx]  = 1'b0;
      end
    end
    head_d = head_q + n_commit[ROB_W-1:0];

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else if (recover_i) begin
      // Age is distance from head; anything older than the tag survives.
      for (int t = 0; t < DEPTH; t++) begin
        off = ROB_W'(t) - head_q;
        if (off > rel)
          valid_d[t] = 1'b0;
      end
      tail_d  = recover_tag_i + ROB_W'(1);
      count_d = {1'b0, rel} + (ROB_W+1)'(1) - n_commit;
    end else begin
      for (int i = 0; i < ALLOC_W; i++) begin
        idx = tail_q + ROB_W'(i);
        if (fire && bus.alloc_valid_i[i]) begin
          valid_d[idx] = 1'b1;
          done_d[idx]  = 1'b0;
          used_d[idx]  = bus.alloc_rd_used_i[i];
          prd_d[idx]   =
            bus.alloc_old_prd_i[i*PREG_W +: PREG_W];
        end
      end
      tail_d  = tail_q + n_alloc[ROB_W-1:0];
      count_d = count_q + n_alloc - n_commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      used_q  <= '0;
      for (int t = 0; t < DEPTH; t++)
        prd_q[t] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      used_q  <= used_d;
      prd_q   <= prd_d;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios and random traffic, all checked
// every cycle against a program-order queue model of the ROB.
module tb_rob_multi;
  localparam int DEPTH = 16;
  localparam int AW    = 2;
  localparam int CW    = 2;
  localparam int WP    = 3;
  localparam int PW    = 7;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          recover_i = 1'b0;
  logic [RW-1:0] recover_tag_i = '0;

  rob_multi_if #(
    .DEPTH(DEPTH), .ALLOC_W(AW), .COMMIT_W(CW),
    .WB_PORTS(WP), .PREG_W(PW)
  ) bus ();

  rob_multi #(
    .DEPTH(DEPTH), .ALLOC_W(AW), .COMMIT_W(CW),
    .WB_PORTS(WP), .PREG_W(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .recover_i(recover_i),
    .recover_tag_i(recover_tag_i),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit done;
    bit used;
    int prd;
  } ent_t;

  ent_t q[$];
  int   head_m = 0;
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lead_done();
    int n = 0;
    while (n < CW && n < q.size() && q[n].done) n++;
    return n;
  endfunction

  // One clock: drive at negedge, compare against model, advance model.
  task automatic step(input logic [1:0]  av,
                      input logic [1:0]  us,
                      input logic [13:0] pr,
                      input logic [2:0]  wv,
                      input logic [11:0] wt,
                      input logic        fl,
                      input logic        rc,
                      input logic [3:0]  rt);
    int sz, n, pos, tail0;
    bit rdy;
    logic [15:0] live;
    logic [7:0]  atag, ect;
    logic [1:0]  ecv, ecf;
    logic [13:0] ecp;
    ent_t e;
    @(negedge clk);
    bus.alloc_valid_i   = av;
    bus.alloc_rd_used_i = us;
    bus.alloc_old_prd_i = pr;
    bus.wb_valid_i      = wv;
    bus.wb_tag_i        = wt;
    flush_i             = fl;
    recover_i           = rc;
    recover_tag_i       = rt;
    #1;
    sz    = q.size();
    rdy   = sz <= DEPTH - AW;
    tail0 = (head_m + sz) % DEPTH;
    live  = '0;
    foreach (q[k]) live[q[k].tag] = 1'b1;
    atag = '0;
    for (int i = 0; i < AW; i++)
      atag[i*4 +: 4] = 4'((tail0 + i) % DEPTH);
    n = 0; ecv = '0; ect = '0; ecf = '0; ecp = '0;
    if (!fl) n = lead_done();
    for (int k = 0; k < n; k++) begin
      ecv[k] = 1'b1;
      ect[k*4 +: 4] = 4'(q[k].tag);
      if (q[k].used && q[k].prd != 0) begin
        ecf[k] = 1'b1;
        ecp[k*7 +: 7] = 7'(q[k].prd);
      end
    end
    chk("count", bus.count_o, 64'(sz));
    chk("ready", bus.alloc_ready_o, 64'(rdy));
    chk("alloc_tag", bus.alloc_tag_o, atag);
    chk("live", bus.live_tag_o, live);
    chk("cvalid", bus.commit_valid_o, ecv);
    chk("ctag", bus.commit_tag_o, ect);
    chk("cfree", bus.commit_free_o, ecf);
    chk("cpreg", bus.commit_preg_o, ecp);
    if (rc && !fl) chk("recover_live", live[rt], 1);

    if (fl) begin
      q.delete();
      head_m = 0;
    end else begin
      pos = -1;
      for (int k = 0; k < sz; k++)
        if (q[k].tag == int'(rt)) pos = k;
      for (int p = 0; p < WP; p++)
        if (wv[p])
          foreach (q[k])
            if (q[k].tag == int'(wt[p*4 +: 4])) q[k].done = 1;
      repeat (n) begin
        void'(q.pop_front());
        head_m = (head_m + 1) % DEPTH;
      end
      if (rc) begin
        while (q.size() > pos + 1 - n) void'(q.pop_back());
      end else if (rdy) begin
        for (int i = 0; i < AW; i++)
          if (av[i]) begin
            e.tag  = (tail0 + i) % DEPTH;
            e.done = 0;
            e.used = us[i];
            e.prd  = int'(pr[i*7 +: 7]);
            q.push_back(e);
          end
      end
    end
  endtask

  task automatic idle();
    step(2'b0, 2'b0, '0, 3'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic alloc2();
    step(2'b11, 2'b0, '0, 3'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic wb(input logic [2:0] wv, input logic [11:0] wt);
    step(2'b0, 2'b0, '0, wv, wt, 1'b0, 1'b0, '0);
  endtask

  task automatic flush();
    step(2'b0, 2'b0, '0, 3'b0, '0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    logic [1:0]  av, us;
    logic [13:0] pr;
    logic [2:0]  wv;
    logic [11:0] wt;
    logic        fl, rc;
    logic [3:0]  rt;
    int          sz, lo;

    bus.alloc_valid_i   = '0;
    bus.alloc_rd_used_i = '0;
    bus.alloc_old_prd_i = '0;
    bus.wb_valid_i      = '0;
    bus.wb_tag_i        = '0;
    #2;
    chk("rst_count", bus.count_o, 0);
    chk("rst_ready", bus.alloc_ready_o, 1);
    chk("rst_atag", bus.alloc_tag_o, 8'h10);
    chk("rst_live", bus.live_tag_o, 0);
    chk("rst_cvalid", bus.commit_valid_o, 0);
    #10 rst_n = 1'b1;

    // out-of-order writeback
    alloc2(); alloc2();
    wb(3'b111, {4'd1, 4'd2, 4'd3});
    idle();
    chk("ooo_hold", bus.commit_valid_o, 2'b00);
    wb(3'b001, 12'h000);
    idle();
    chk("ooo_c01", bus.commit_tag_o, 8'h10);
    idle();
    chk("ooo_c23", bus.commit_tag_o, 8'h32);
    idle();

    // free rules
    flush();
    step(2'b11, 2'b11, {7'd42, 7'd0}, 3'b0, '0, 1'b0, 1'b0, '0);
    wb(3'b011, 12'h010);
    idle();
    chk("free_mask", bus.commit_free_o, 2'b10);
    chk("free_preg", bus.commit_preg_o, 14'd42 << 7);

    // fill and drain
    flush();
    repeat (8) alloc2();
    idle();
    chk("full_count", bus.count_o, 16);
    chk("full_ready", bus.alloc_ready_o, 0);
    for (int b = 0; b < 16; b += 3)
      wb(3'b111, {4'((b + 2) % 16), 4'((b + 1) % 16), 4'(b)});
    repeat (8) idle();
    chk("drain_count", bus.count_o, 0);

    // recover across the wrap with same-cycle commit
    flush();
    repeat (7) alloc2();
    for (int b = 0; b < 14; b += 3)
      wb(3'b111, {4'((b + 2) % 14), 4'((b + 1) % 14), 4'(b)});
    repeat (8) idle();
    chk("wrap_head", bus.alloc_tag_o, 8'hFE);
    repeat (4) alloc2();
    wb(3'b011, {4'd0, 4'd15, 4'd14});
    step(2'b0, 2'b0, '0, 3'b0, '0, 1'b0, 1'b1, 4'd1);
    chk("rec_ctag", bus.commit_tag_o, 8'hFE);
    idle();
    chk("rec_count", bus.count_o, 2);
    chk("rec_live", bus.live_tag_o, 16'h0003);
    chk("rec_tail", bus.alloc_tag_o, 8'h32);

    // flush and recover together
    wb(3'b001, 12'h000);
    step(2'b0, 2'b0, '0, 3'b0, '0, 1'b1, 1'b1, 4'd1);
    chk("fr_nocommit", bus.commit_valid_o, 2'b00);
    idle();
    chk("fr_count", bus.count_o, 0);

    // asynchronous reset with traffic in flight
    repeat (5) alloc2();
    idle();
    chk("pre_rst_count", bus.count_o, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count_o, 0);
    chk("arst_live", bus.live_tag_o, 0);
    chk("arst_ready", bus.alloc_ready_o, 1);
    chk("arst_cvalid", bus.commit_valid_o, 0);
    rst_n = 1'b1;
    q.delete();
    head_m = 0;
    idle();
    chk("arst_atag", bus.alloc_tag_o, 8'h10);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      sz = q.size();
      case ($urandom_range(0, 3))
        0:       av = 2'b00;
        1:       av = 2'b01;
        default: av = 2'b11;
      endcase
      us = 2'($urandom_range(0, 3));
      pr = 14'($urandom);
      if ($urandom_range(0, 3) == 0) pr[6:0] = '0;
      for (int p = 0; p < WP; p++) begin
        wv[p] = $urandom_range(0, 2) != 0;
        if (sz > 0 && $urandom_range(0, 4) != 0)
          wt[p*4 +: 4] = 4'(q[$urandom_range(0, sz - 1)].tag);
        else
          wt[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      fl = $urandom_range(0, 99) == 0;
      rc = sz > 0 && $urandom_range(0, 19) == 0;
      rt = '0;
      if (rc) begin
        lo = lead_done() - 1;
        if (lo < 0) lo = 0;
        rt = 4'(q[$urandom_range(lo, sz - 1)].tag);
      end
      step(av, us, pr, wv, wt, fl, rc, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
